// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter with selectable bit order, word-abort sync,
// a one-word holding register with a valid/ready handshake, and a sticky overrun flag.
module serial_deserializer #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sin,
    input  logic                   sin_valid,
    input  logic                   dir,
    input  logic                   sync,
    input  logic                   out_ready,
    input  logic                   clr_ovr,
    output logic [N-1:0]           data_out,
    output logic                   out_valid,
    output logic                   overrun,
    output logic [$clog2(N):0]     bit_cnt
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   shift_reg;
    logic           dir_lat;
    logic           dir_eff;
    logic [N-1:0]   shift_nxt;
    logic           accept;
    logic           last_bit;
    logic           consume;
    logic           load;
    logic           drop;

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur,
                                              input logic lsb_first,
                                              input logic b);
        if (lsb_first)
            shift_in = {b, cur[N-1:1]};
        else
            shift_in = {cur[N-2:0], b};
    endfunction

    // The first bit of a word uses the live dir input; later bits use the latched copy.
    assign accept    = sin_valid && !sync;
    assign dir_eff   = (bit_cnt == '0) ? dir : dir_lat;
    assign shift_nxt = shift_in(shift_reg, dir_eff, sin);
    assign last_bit  = accept && (bit_cnt == CW'(N - 1));
    assign consume   = (state == FULL) && out_ready;
    assign out_valid = (state == FULL);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (last_bit) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (last_bit && out_ready) begin
                    load = 1'b1;
                end else if (last_bit) begin
                    drop = 1'b1;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            dir_lat   <= 1'b0;
        end else if (sync) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            if (bit_cnt == '0)
                dir_lat <= dir;
            if (last_bit) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else begin
                shift_reg <= shift_nxt;
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

    // A new overrun on the same edge as a clear request wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            overrun  <= 1'b0;
        end else begin
            if (load)
                data_out <= shift_nxt;
            if (drop)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter N, default 8, SHALL be the parallel word width in bits.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 SIN  input  1  SHALL be the serial data bit.
REQ-005 SIN_VALID  input  1  SHALL qualify SIN; a bit is accepted on each rising edge where SIN_VALID=1.
REQ-006 DIR  input  1  SHALL select bit order: 0 = MSB-first (shift left, new bit into bit 0); 1 = LSB-first (shift right, new bit into bit N-1).
REQ-007 SYNC  input  1  SHALL abort any partial word and restart bit counting.
REQ-008 OUT_READY  input  1  SHALL be the consumer's acceptance of DATA_OUT.
REQ-009 CLR_OVR  input  1  SHALL clear the OVERRUN flag.
REQ-010 DATA_OUT  output  N  SHALL be the last completed word (holding register).
REQ-011 OUT_VALID  output  1  SHALL indicate DATA_OUT holds an unconsumed word.
REQ-012 OVERRUN  output  1  SHALL be a sticky flag for a dropped word.
REQ-013 BIT_CNT  output  clog2(N)+1  SHALL be the number of bits accepted in the current partial word.

Function
REQ-014 The block SHALL hold an internal N-bit shift register and a bit counter running 0..N-1.
REQ-015 DIR SHALL be latched when the first bit of a word is accepted (BIT_CNT=0); DIR changes mid-word SHALL have no effect until the next word.
REQ-016 Each accepted bit SHALL shift in per the latched DIR and increment BIT_CNT.
REQ-017 Cycles with SIN_VALID=0 SHALL leave the shift register and BIT_CNT unchanged (gaps allowed anywhere).
REQ-018 On the edge accepting the Nth bit, the complete word (including that bit) SHALL be written to DATA_OUT, OUT_VALID SHALL be set, and BIT_CNT SHALL return to 0; latency from Nth bit to OUT_VALID=1 is that same edge.
REQ-019 Handshake: a word SHALL be consumed on an edge where OUT_VALID=1 and OUT_READY=1; OUT_VALID SHALL then clear unless a new word completes on that edge.
REQ-020 DATA_OUT SHALL stay stable while OUT_VALID=1 and not consumed.
REQ-021 Word completes while OUT_VALID=1 and OUT_READY=0: the new word SHALL be dropped, DATA_OUT retained, OVERRUN set.
REQ-022 Word completes on the same edge as a consumption: the new word SHALL be loaded, OUT_VALID SHALL remain 1, OVERRUN unchanged.
REQ-023 SYNC=1 SHALL clear BIT_CNT and the shift register on that edge and take priority over an accepted bit that edge; DATA_OUT/OUT_VALID/OVERRUN unaffected.
REQ-024 CLR_OVR=1 SHALL clear OVERRUN; if a new overrun occurs on the same edge, set SHALL win.
REQ-025 Control states SHALL be EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1); EMPTY->FULL on word completion, FULL->EMPTY on consumption without new completion, FULL->FULL otherwise.

Reset
REQ-026 RST=1 SHALL immediately force DATA_OUT=0, OUT_VALID=0, OVERRUN=0, BIT_CNT=0, shift register=0, latched DIR=0, regardless of CLK.
REQ-027 Reset asserted mid-word SHALL discard the partial word; the first bit accepted after release SHALL be bit 1 of a new word.

Verification
REQ-028 Reset mid-word: accept 3 bits, pulse RST between edges -> BIT_CNT=0, all outputs 0 immediately; then 8 bits of 0xA5 MSB-first -> DATA_OUT=0xA5.
REQ-029 Bit order: stream 1,1,1,1,0,0,0,0 with DIR=1 -> DATA_OUT=0x0F; same stream with DIR=0 -> DATA_OUT=0xF0; OUT_VALID=1 on the 8th accepting edge.
REQ-030 Gaps and DIR change: 0xA5 MSB-first with SIN_VALID=0 for 2 cycles after bits 3 and 6, DIR toggled after bit 4 -> DATA_OUT=0xA5, BIT_CNT holds during gaps.
REQ-031 Overrun: OUT_READY=0, send 0x12 then 0x34 -> DATA_OUT=0x12, OUT_VALID=1, OVERRUN=1; CLR_OVR pulse -> OVERRUN=0.
REQ-032 Simultaneous: 0x12 pending, OUT_READY=1 exactly on 0x34's 8th edge -> DATA_OUT=0x34, OUT_VALID=1, OVERRUN=0.
REQ-033 SYNC: accept 5 bits, SYNC=1 with SIN_VALID=1 -> BIT_CNT=0 after edge; next 8 bits of 0x5A -> DATA_OUT=0x5A.
